// File: rtl/ice40_spi_master_controller.sv
// ice40_spi_master_controller
// Drives the iCE40 UltraPlus SB_SPI hard block through its system-bus
// register port as an SPI master. It programs the configuration registers
// once after reset, then sends one byte per accepted `start` request.
// Each byte is sent by polling SPISR until TRDY is set and then writing
// the byte to SPITXDR.
//
// Bus handshake (every register access):
//   - Address, data and direction are driven together with spi_strobe.
//   - All four stay stable until spi_ack is sampled high.
//   - The strobe drops on the edge that samples the ack. Read data is
//     taken on that same edge.
//   - The next strobe rises only after at least one cycle with the strobe
//     low, and only once spi_ack is sampled low again.
//
// Optional feature: define ICE40_SPI_MASTER_DEBUG_EN to add the b/g/r
// debug status outputs.

module ice40_spi_master_controller #(
    parameter int unsigned CLK_DIVIDER = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_out,
    input  logic [7:0] spi_data_out,
    input  logic       spi_ack,
    output logic       spi_rw,
    output logic [7:0] spi_reg_addr,
    output logic       spi_strobe,
    output logic [7:0] spi_data_in,
    output logic       busy
`ifdef ICE40_SPI_MASTER_DEBUG_EN
    ,
    output logic       b,
    output logic       g,
    output logic       r
`endif
);

    // SB_SPI register map for the instance at address nibble 0x0
    localparam logic [7:0] ADDR_SPICR0  = 8'h08;
    localparam logic [7:0] ADDR_SPICR1  = 8'h09;
    localparam logic [7:0] ADDR_SPICR2  = 8'h0A;
    localparam logic [7:0] ADDR_SPIBR   = 8'h0B;
    localparam logic [7:0] ADDR_SPISR   = 8'h0C;
    localparam logic [7:0] ADDR_SPITXDR = 8'h0D;
    localparam logic [7:0] ADDR_SPICSR  = 8'h0F;

    // Only the low six bits of the divider reach the baud-rate register
    localparam logic [5:0] BR_DIV       = CLK_DIVIDER[5:0];
    localparam logic [2:0] LAST_INIT    = 3'd4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_POLL = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] init_step;
    // Set while a strobe is outstanding, i.e. we are waiting for the ack
    logic       pending;
    logic [7:0] tx_byte;
    logic [7:0] init_addr;
    logic [7:0] init_data;

    // Only TRDY (bit 4) of SPISR drives the sequencer
    logic unused_status_bits;
    assign unused_status_bits = ^{spi_data_out[7:5], spi_data_out[3:0]};

    // Configuration write table, indexed by the init step
    always_comb begin
        init_addr = ADDR_SPICR0;
        init_data = 8'h00;
        case (init_step)
            3'd0:    begin init_addr = ADDR_SPICR0; init_data = 8'h00;             end
            3'd1:    begin init_addr = ADDR_SPICR1; init_data = 8'h80;             end
            3'd2:    begin init_addr = ADDR_SPICR2; init_data = 8'h80;             end
            3'd3:    begin init_addr = ADDR_SPIBR;  init_data = {2'b00, BR_DIV};   end
            3'd4:    begin init_addr = ADDR_SPICSR; init_data = 8'h00;             end
            default: begin init_addr = ADDR_SPICR0; init_data = 8'h00;             end
        endcase
    end

    // Main sequencer: init writes, idle wait, SPISR poll and TXDR write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_INIT;
            init_step    <= 3'd0;
            pending      <= 1'b0;
            tx_byte      <= 8'h00;
            spi_rw       <= 1'b0;
            spi_reg_addr <= 8'h00;
            spi_data_in  <= 8'h00;
            spi_strobe   <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!pending) begin
                        if (!spi_ack) begin
                            spi_rw       <= 1'b1;
                            spi_reg_addr <= init_addr;
                            spi_data_in  <= init_data;
                            spi_strobe   <= 1'b1;
                            pending      <= 1'b1;
                        end
                    end else if (spi_ack) begin
                        spi_strobe <= 1'b0;
                        pending    <= 1'b0;
                        if (init_step == LAST_INIT) begin
                            init_step <= 3'd0;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            init_step <= init_step + 3'd1;
                        end
                    end
                end

                ST_IDLE: begin
                    if (start) begin
                        tx_byte <= data_out;
                        busy    <= 1'b1;
                        state   <= ST_POLL;
                    end
                end

                ST_POLL: begin
                    if (!pending) begin
                        if (!spi_ack) begin
                            spi_rw       <= 1'b0;
                            spi_reg_addr <= ADDR_SPISR;
                            spi_data_in  <= 8'h00;
                            spi_strobe   <= 1'b1;
                            pending      <= 1'b1;
                        end
                    end else if (spi_ack) begin
                        spi_strobe <= 1'b0;
                        pending    <= 1'b0;
                        // TRDY set: transmitter can take a byte
                        if (spi_data_out[4]) begin
                            state <= ST_TX;
                        end
                    end
                end

                ST_TX: begin
                    if (!pending) begin
                        if (!spi_ack) begin
                            spi_rw       <= 1'b1;
                            spi_reg_addr <= ADDR_SPITXDR;
                            spi_data_in  <= tx_byte;
                            spi_strobe   <= 1'b1;
                            pending      <= 1'b1;
                        end
                    end else if (spi_ack) begin
                        spi_strobe <= 1'b0;
                        pending    <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state   <= ST_INIT;
                    pending <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICE40_SPI_MASTER_DEBUG_EN
    // Registered colour-coded status: red init, green idle, blue transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= 1'b0;
            g <= 1'b0;
            b <= 1'b0;
        end else begin
            r <= (state == ST_INIT);
            g <= (state == ST_IDLE);
            b <= (state == ST_POLL) || (state == ST_TX);
        end
    end
`endif

endmodule

// File: tb/tb_ice40_spi_master_controller.sv
// Directed testbench for ice40_spi_master_controller.
// A small SB_SPI bus responder acks every strobe two cycles after it
// rises. It logs each completed access as {rw, addr, data} and supplies
// SPISR values from a queue.
// Expected accesses are queued in exp_q and compared in order.

module tb_ice40_spi_master_controller;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic [7:0] spi_data_out = 8'h00;
    logic       spi_ack = 1'b0;
    logic       spi_rw;
    logic [7:0] spi_reg_addr;
    logic       spi_strobe;
    logic [7:0] spi_data_in;
    logic       busy;
`ifdef ICE40_SPI_MASTER_DEBUG_EN
    logic       dbg_b, dbg_g, dbg_r;
`endif

    always #5 clk = ~clk;

    ice40_spi_master_controller #(.CLK_DIVIDER(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_out     (data_out),
        .spi_data_out (spi_data_out),
        .spi_ack      (spi_ack),
        .spi_rw       (spi_rw),
        .spi_reg_addr (spi_reg_addr),
        .spi_strobe   (spi_strobe),
        .spi_data_in  (spi_data_in),
        .busy         (busy)
`ifdef ICE40_SPI_MASTER_DEBUG_EN
        ,
        .b            (dbg_b),
        .g            (dbg_g),
        .r            (dbg_r)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [7:0]  sr_q[$];
    int          lat_cnt = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic logic [16:0] txn(input logic rw, input logic [7:0] addr,
                                        input logic [7:0] data);
        return {rw, addr, data};
    endfunction

    // ---------------- SB_SPI responder ----------------
    // Works on the falling edge so its view of the DUT is settled. Ack is
    // high across exactly one rising edge.
    always @(negedge clk) begin
        if (reset) begin
            spi_ack = 1'b0;
            lat_cnt = 0;
        end else if (spi_ack) begin
            spi_ack = 1'b0;
        end else if (spi_strobe) begin
            if (lat_cnt == 1) begin
                lat_cnt = 0;
                obs_q.push_back({spi_rw, spi_reg_addr, spi_data_in});
                if (!spi_rw && spi_reg_addr == 8'h0C) begin
                    if (sr_q.size() > 0) spi_data_out = sr_q.pop_front();
                    else                 spi_data_out = 8'h10;
                end
                spi_ack = 1'b1;
            end else begin
                lat_cnt = lat_cnt + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag);
        logic [16:0] exp;
        logic [16:0] obs;
        int waited;
        waited = 0;
        exp = exp_q.pop_front();
        while (obs_q.size() == 0 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        tests_run++;
        assert (obs_q.size() != 0) else begin
            tests_failed++;
            $error("FAIL %s: observed no access (timeout) expected %h", tag, exp);
            return;
        end
        obs = obs_q.pop_front();
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed rw/addr/data %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(txn(1'b1, 8'h08, 8'h00));
        exp_q.push_back(txn(1'b1, 8'h09, 8'h80));
        exp_q.push_back(txn(1'b1, 8'h0A, 8'h80));
        exp_q.push_back(txn(1'b1, 8'h0B, 8'h01));
        exp_q.push_back(txn(1'b1, 8'h0F, 8'h00));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // 1. Reset state
        @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'd0, busy},       32'd1);
        check("reset_strobe", {31'd0, spi_strobe}, 32'd0);
        check("reset_rw",     {31'd0, spi_rw},     32'd0);
        check("reset_addr",   {24'd0, spi_reg_addr}, 32'h00);
        check("reset_data",   {24'd0, spi_data_in},  32'h00);
        reset = 1'b0;

        // First strobe must be up by the 2nd rising edge after release
        @(posedge clk);
        @(posedge clk);
        #1;
        check("first_strobe", {31'd0, spi_strobe}, 32'd1);
        check("first_addr",   {24'd0, spi_reg_addr}, 32'h08);

        // 2. start pulsed during INIT must be ignored
        start = 1'b1;
        data_out = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        push_init();
        check_next("init_cr0");
        check_next("init_cr1");
        check_next("init_cr2");
        check_next("init_br");
        check_next("init_csr");
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("idle_no_access", obs_q.size(), 32'd0);
        check("idle_strobe",    {31'd0, spi_strobe}, 32'd0);
        check("idle_busy_hold", {31'd0, busy}, 32'd0);

        // 3. Re-init, start raised during the SPICSR write, TRDY at once
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push_init();
        check_next("reinit_cr0");
        check_next("reinit_cr1");
        check_next("reinit_cr2");
        check_next("reinit_br");
        check_next("reinit_csr");
        start = 1'b1;
        data_out = 8'hAA;
        sr_q.push_back(8'h10);
        exp_q.push_back(txn(1'b0, 8'h0C, 8'h00));
        exp_q.push_back(txn(1'b1, 8'h0D, 8'hAA));
        check_next("tx1_poll");
        start = 1'b0;
        data_out = 8'h55;   // must not disturb the latched 0xAA
        check_next("tx1_write");
        check("tx1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("tx1_done_busy", {31'd0, busy}, 32'd0);

        // 4. TRDY low three times, then high: four polls, one write
        sr_q.push_back(8'h00);
        sr_q.push_back(8'h00);
        sr_q.push_back(8'h00);
        sr_q.push_back(8'h10);
        data_out = 8'h3C;
        start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(txn(1'b0, 8'h0C, 8'h00));
        exp_q.push_back(txn(1'b1, 8'h0D, 8'h3C));
        check_next("poll_a");
        start = 1'b0;
        check_next("poll_b");
        check_next("poll_c");
        check_next("poll_d");
        check_next("tx2_write");
        repeat (20) @(negedge clk);
        check("tx2_no_extra", obs_q.size(), 32'd0);

        // 5. start held high: back-to-back pairs, one idle cycle between
        data_out = 8'h11;
        start = 1'b1;
        exp_q.push_back(txn(1'b0, 8'h0C, 8'h00));
        exp_q.push_back(txn(1'b1, 8'h0D, 8'h11));
        exp_q.push_back(txn(1'b0, 8'h0C, 8'h00));
        exp_q.push_back(txn(1'b1, 8'h0D, 8'h22));
        check_next("b2b_poll1");
        check_next("b2b_write1");
        data_out = 8'h22;
        @(negedge clk);
        check("b2b_idle_gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_rebusy", {31'd0, busy}, 32'd1);
        check_next("b2b_poll2");
        start = 1'b0;
        check_next("b2b_write2");

        // 6. Reset while the SPITXDR strobe is high
        data_out = 8'h77;
        start = 1'b1;
        exp_q.push_back(txn(1'b0, 8'h0C, 8'h00));
        check_next("rst_poll");
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_tx_strobe", {31'd0, spi_strobe}, 32'd1);
        check("rst_tx_addr",   {24'd0, spi_reg_addr}, 32'h0D);
        check("rst_tx_data",   {24'd0, spi_data_in},  32'h77);
        reset = 1'b1;
        #1;
        check("rst_async_strobe", {31'd0, spi_strobe}, 32'd0);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        push_init();
        check_next("rst_cr0");
        check_next("rst_cr1");
        check_next("rst_cr2");
        check_next("rst_br");
        check_next("rst_csr");
        repeat (10) @(negedge clk);
        check("rst_no_stale_tx", obs_q.size(), 32'd0);
        check("rst_idle_busy",   {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ice40_spi_master_controller.md
# ice40_spi_master_controller

Sequencer that drives the iCE40 UltraPlus hard SPI block (SB_SPI) through its system-bus register interface, configured as SPI master. After reset it programs the SPI configuration registers once. It then transmits one byte per `start` request by polling SPISR for TRDY and writing SPITXDR. It sits between user logic and the SB_SPI primitive's SBADRI/SBDATI/SBDATO/SBSTBI/SBRWI/SBACKO pins.

## Interface
Parameters:
- `CLK_DIVIDER`, default 7: SPI baud-rate divider. Only bits [5:0] are used; valid range 0..63.

Ports:
- `clk`  in  1: single system clock; everything is synchronous to its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: level request to transmit `data_out`; sampled only when idle.
- `data_out`  in  8: byte to transmit; latched when `start` is accepted.
- `spi_data_out`  in  8: read data from SB_SPI (SBDATO).
- `spi_ack`  in  1: SB_SPI transaction acknowledge (SBACKO).
- `spi_rw`  out  1: 1 = register write, 0 = register read (SBRWI).
- `spi_reg_addr`  out  8: register address (SBADRI).
- `spi_strobe`  out  1: bus transaction strobe (SBSTBI).
- `spi_data_in`  out  8: register write data (SBDATI).
- `busy`  out  1: high during reset, initialisation and transfers; low only when idle.
- `b`, `g`, `r`  out  1 each: debug status; present only with `ICE40_SPI_MASTER_DEBUG_EN`.

## Operation
Register addresses (SPI instance at address nibble 0x0):
- SPICR0=0x08, SPICR1=0x09, SPICR2=0x0A, SPIBR=0x0B, SPISR=0x0C, SPITXDR=0x0D, SPIRXDR=0x0E, SPICSR=0x0F.

Register-access primitive (write or read):
- Drive `spi_rw`, `spi_reg_addr` and `spi_data_in`, and raise `spi_strobe`. Hold all four stable until `spi_ack` is sampled high.
- On the edge that samples `spi_ack`=1: drop `spi_strobe`. For a read, capture `spi_data_out` on the same edge.
- Before raising the next strobe, keep `spi_strobe` low for at least one cycle and wait until `spi_ack` is sampled low.

State sequence:
- INIT, writes in order: SPICR0←0x00, SPICR1←0x80 (SPE), SPICR2←0x80 (MSTR, mode 0), SPIBR←{2'b00, CLK_DIVIDER[5:0]}, SPICSR←0x00.
- IDLE: `busy`=0. When `start`=1, latch `data_out`, set `busy`=1 and go to POLL.
- POLL: read SPISR. If bit 4 (TRDY) is 1, go to TX; otherwise repeat the SPISR read.
- TX: write SPITXDR←latched byte. On ack completion return to IDLE.
- Holding `start` high re-triggers another transfer (a fresh SPISR poll) after returning to IDLE.
- `start` is ignored outside IDLE, including during INIT.
- Changes to `data_out` after it is latched do not affect the current transfer.

## Timing
- Reset values: `spi_strobe`=0, `spi_rw`=0, `spi_reg_addr`=0x00, `spi_data_in`=0x00, `busy`=1, state=INIT step 0.
- Reset asserted mid-transaction: strobe drops immediately (asynchronously), any latched byte is discarded, and the full INIT sequence restarts after reset release.
- The first strobe (SPICR0 write) rises no later than the 2nd rising edge after reset deasserts.
- `busy` falls on the edge that completes the SPICSR write ack.
- `busy` rises on the edge that samples `start` in IDLE and stays high through the SPITXDR ack.
- Per access: 1 cycle to assert the strobe, N cycles of SB_SPI latency until ack, at least 1 cycle with strobe low.
- No timeout applies: POLL repeats indefinitely while TRDY=0.

## Configuration
- `ICE40_SPI_MASTER_DEBUG_EN` defined: ports `b`, `g`, `r` exist, active-high.
  - `r`=1 in INIT.
  - `g`=1 in IDLE.
  - `b`=1 in POLL or TX.
  - All three are 0 in reset.
- Undefined: the ports and their logic are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset held 1 cycle → `busy`=1 and `spi_strobe`=0. After release the strobes appear in order: write 0x08←0x00, 0x09←0x80, 0x0A←0x80, 0x0B←0x01 (`CLK_DIVIDER`=1), 0x0F←0x00, with `spi_rw`=1 on each.
- Model acks after 2 cycles; assert `start` with `data_out`=0xAA during the SPICSR write → next strobe is a read (`spi_rw`=0) of 0x0C. SPISR returns 0x10 → next strobe writes 0x0D←0xAA with `busy`=1.
- SPISR returns 0x00 three times, then 0x10 → exactly four SPISR reads, then one SPITXDR write.
- `start` pulsed while in INIT → no transfer occurs. After INIT, `busy`=0 and no further strobes.
- Reset asserted while the strobe is high during the TXDR write → strobe drops immediately and INIT restarts from the SPICR0 write.
- `start` held high → back-to-back SPISR/SPITXDR pairs. `busy` drops for one idle cycle between transfers.
